mvm_sched: RTL and testbench

MVM_SCHED -- requirements
Module: mvm_sched

---
 rtl/mvm_pkg.sv | 17 +
 rtl/mvm_sched_if.sv | 38 +++
 rtl/mvm_nz_find.sv | 24 ++
 rtl/mvm_sched.sv | 115 +++++++++++
 tb/tb_mvm_sched.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mvm_pkg.sv
// Shared defaults, FSM state encoding and a small popcount helper for the
// sparse matrix-vector scheduler.
package mvm_pkg;
    localparam int N_DEF       = 4;
    localparam int M_DEF       = 4;
    localparam int W_DEF       = 8;
    localparam int MAC_LAT_DEF = 2;

    typedef enum logic [2:0] {LOAD, CLR, ISSUE, WAIT, OUT} state_t;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) c = c + 32'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/mvm_sched_if.sv
// Load / MAC-issue / row-result handshakes plus status of the scheduler.
interface mvm_sched_if
    import mvm_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int W = W_DEF
) ();
    localparam int AW = $clog2(M * N);
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int NW = $clog2(N) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_data;
    logic                 mac_valid;
    logic                 mac_ready;
    logic [AW-1:0]        w_addr;
    logic signed [W-1:0]  mac_x;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [RW-1:0]        out_row;
    logic                 busy;
    logic [NW-1:0]        nnz;
    logic                 done;

    modport master (
        input  in_valid, in_data, mac_ready, out_ready,
        output in_ready, mac_valid, w_addr, mac_x, acc_clr,
               out_valid, out_row, busy, nnz, done
    );
    modport slave (
        output in_valid, in_data, mac_ready, out_ready,
        input  in_ready, mac_valid, w_addr, mac_x, acc_clr,
               out_valid, out_row, busy, nnz, done
    );
endinterface

// File: rtl/mvm_nz_find.sv
// Combinational finder: lowest set mask bit at or above (incl) / strictly
// above (!incl) the start index.
module mvm_nz_find #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    input  logic          incl,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // descending scan so the lowest qualifying bit wins
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (incl ? (i >= int'(start)) : (i > int'(start)))) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mvm_sched.sv
// Sparse MVM scheduler: loads a vector, then per matrix row clears the
// accumulator, issues only nonzero columns, waits out the MAC latency, reports.
module mvm_sched
    import mvm_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int M       = M_DEF,
    parameter int W       = W_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input logic         clk,
    input logic         rst,
    mvm_sched_if.master bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int NW = $clog2(N) + 1;
    localparam int CW = $clog2(MAC_LAT + 1);

    state_t               state;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        col;
    logic [RW-1:0]        row;
    logic [N-1:0]         mask;
    logic [N-1:0]         mask_ld;
    logic [N-1:0][W-1:0]  x;
    logic [NW-1:0]        nnz;
    logic [CW-1:0]        cnt;
    logic                 done_r;
    logic [IW-1:0]        find_start;
    logic [IW-1:0]        nz_idx;
    logic                 nz_found;

    // mask including the element being accepted this cycle
    always_comb begin
        mask_ld      = mask;
        mask_ld[idx] = (bus.in_data != '0);
    end

    assign find_start = (state == CLR) ? '0 : col;

    mvm_nz_find #(.N(N), .IW(IW)) u_find (
        .mask  (mask),
        .start (find_start),
        .incl  (state == CLR),
        .idx   (nz_idx),
        .found (nz_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LOAD;
            idx    <= '0;
            col    <= '0;
            row    <= '0;
            mask   <= '0;
            x      <= '0;
            nnz    <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                LOAD: if (bus.in_valid) begin
                    x[idx] <= bus.in_data;
                    mask   <= mask_ld;
                    idx    <= idx + 1'b1;
                    if (idx == IW'(N - 1)) begin
                        nnz   <= NW'(popcount(64'(mask_ld)));
                        row   <= '0;
                        state <= CLR;
                    end
                end
                CLR: begin
                    col   <= nz_found ? nz_idx : '0;
                    state <= nz_found ? ISSUE : OUT;
                end
                ISSUE: if (bus.mac_ready) begin
                    if (nz_found) begin
                        col <= nz_idx;
                    end else begin
                        cnt   <= CW'(MAC_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(1)) state <= OUT;
                    else               cnt   <= cnt - 1'b1;
                end
                OUT: if (bus.out_ready) begin
                    if (row == RW'(M - 1)) begin
                        state  <= LOAD;
                        idx    <= '0;
                        done_r <= 1'b1;
                    end else begin
                        row   <= row + 1'b1;
                        state <= CLR;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.busy      = (state != LOAD);
    assign bus.acc_clr   = (state == CLR);
    assign bus.mac_valid = (state == ISSUE);
    assign bus.out_valid = (state == OUT);
    assign bus.w_addr    = {row, col};
    assign bus.mac_x     = x[col];
    assign bus.out_row   = row;
    assign bus.nnz       = nnz;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_mvm_sched.sv
// Directed bench: an event-queue model of the row schedule is checked against
// every acc_clr / MAC issue / row result, plus hand-computed timing literals.
module tb_mvm_sched;
    import mvm_pkg::*;
    localparam int N = N_DEF;
    localparam int M = M_DEF;
    localparam int W = W_DEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mvm_sched_if #(.N(N), .M(M), .W(W)) bus ();
    mvm_sched #(.N(N), .M(M), .W(W), .MAC_LAT(MAC_LAT_DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {int kind; int a; int b;} ev_t;  // kind 0=clr 1=issue 2=result
    ev_t q[$];

    int checks = 0, failures = 0;
    int cyc = 0, t_clr0 = -1, t_done = 0;
    int vec_issues = 0, vec_clrs = 0, done_total = 0;
    int mac_stall_at = 0, mac_stall_left = 0, mac_stalls = 0, stall_addr = -1, stall_x = -1;
    int out_stall_row = -1, out_stall_left = 0, out_stalls = 0, stall_row = -1;
    bit prev_ms = 0, prev_os = 0;
    int prev_addr = 0, prev_x = 0, prev_row = 0;
    int vec[N], vec2[N];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int a, input int b);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d (a=%0d) expected none", kind, a);
        end else begin
            e = q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_a", a, e.a);
            check("ev_b", b, e.b);
        end
    endtask

    // per row: clear, one issue per nonzero column in ascending order, result
    task automatic push_model(input int v[N]);
        for (int r = 0; r < M; r++) begin
            q.push_back('{0, 0, 0});
            for (int c = 0; c < N; c++)
                if (v[c] != 0) q.push_back('{1, r * N + c, v[c]});
            q.push_back('{2, r, 0});
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_ms = 0;
            prev_os = 0;
        end else begin
            check("ready_vs_busy", int'(bus.in_ready), int'(!bus.busy));
            if (prev_ms) begin
                check("mac_hold_valid", int'(bus.mac_valid), 1);
                check("mac_hold_addr", int'(bus.w_addr), prev_addr);
                check("mac_hold_x", int'(bus.mac_x), prev_x);
            end
            if (prev_os) begin
                check("out_hold_valid", int'(bus.out_valid), 1);
                check("out_hold_row", int'(bus.out_row), prev_row);
            end
            if (bus.acc_clr) begin
                vec_clrs++;
                if (t_clr0 < 0) t_clr0 = cyc;
                expect_ev(0, 0, 0);
            end
            if (bus.mac_valid && bus.mac_ready) begin
                vec_issues++;
                expect_ev(1, int'(bus.w_addr), int'(bus.mac_x));
            end
            if (bus.out_valid && bus.out_ready) expect_ev(2, int'(bus.out_row), 0);
            if (bus.mac_valid && !bus.mac_ready) begin
                mac_stalls++;
                stall_addr = int'(bus.w_addr);
                stall_x    = int'(bus.mac_x);
            end
            if (bus.out_valid && !bus.out_ready) begin
                out_stalls++;
                stall_row = int'(bus.out_row);
            end
            if (bus.done) begin
                done_total++;
                t_done = cyc;
            end
            prev_ms   = bus.mac_valid && !bus.mac_ready;
            prev_os   = bus.out_valid && !bus.out_ready;
            prev_addr = int'(bus.w_addr);
            prev_x    = int'(bus.mac_x);
            prev_row  = int'(bus.out_row);
        end
    end

    // backpressure generator
    initial begin
        bus.mac_ready = 1'b1;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (mac_stall_left > 0 && bus.mac_valid && vec_issues == mac_stall_at - 1) begin
                bus.mac_ready = 1'b0;
                mac_stall_left--;
            end else bus.mac_ready = 1'b1;
            if (out_stall_left > 0 && bus.out_valid && int'(bus.out_row) == out_stall_row) begin
                bus.out_ready = 1'b0;
                out_stall_left--;
            end else bus.out_ready = 1'b1;
        end
    end

    task automatic check_reset();
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_mac_valid", int'(bus.mac_valid), 0);
        check("rst_acc_clr", int'(bus.acc_clr), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_w_addr", int'(bus.w_addr), 0);
        check("rst_mac_x", int'(bus.mac_x), 0);
        check("rst_out_row", int'(bus.out_row), 0);
        check("rst_nnz", int'(bus.nnz), 0);
    endtask

    task automatic start_vec(input int v[N], input int q_exp);
        vec_issues = 0;
        vec_clrs   = 0;
        t_clr0     = -1;
        push_model(v);
        if (q_exp >= 0) check("model_len", q.size(), q_exp);
    endtask

    task automatic load_vec(input int v[N], input bit hold, input int hold_data);
        for (int i = 0; i < N; i++) begin
            int k = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = W'(v[i]);
            while (!bus.in_ready && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            if (k >= 200) check("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        if (hold) bus.in_data = W'(hold_data);
        else      bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!bus.done && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", int'(bus.done), 1);
        check("queue_drained", q.size(), 0);
    endtask

    task automatic run_vec(input int v[N], input int q_exp, input int nnz_exp, input int el_exp);
        start_vec(v, q_exp);
        load_vec(v, 1'b0, 0);
        check("nnz", int'(bus.nnz), nnz_exp);
        wait_done();
        @(negedge clk); #1;
        check("elapsed", t_done - t_clr0, el_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset();

        // sparse vector, 6 cycles per row
        vec = '{0, 5, 0, -3};
        run_vec(vec, 16, 2, 24);
        check("t1_issues", vec_issues, 8);

        // all-zero vector: CLR -> OUT only
        vec = '{0, 0, 0, 0};
        run_vec(vec, 8, 0, 8);
        check("t2_issues", vec_issues, 0);
        check("t2_clrs", vec_clrs, 4);

        // dense vector, second issue stalled 3 cycles
        mac_stalls = 0; mac_stall_at = 2; mac_stall_left = 3;
        vec = '{1, 2, 3, 4};
        run_vec(vec, 24, 4, 35);
        check("t3_issues", vec_issues, 16);
        check("t3_stalls", mac_stalls, 3);
        check("t3_stall_addr", stall_addr, 1);
        check("t3_stall_x", stall_x, 2);

        // row 2 result held 5 cycles
        out_stalls = 0; out_stall_row = 2; out_stall_left = 5;
        vec = '{7, 0, 0, 0};
        run_vec(vec, 12, 1, 25);
        check("t4_out_stalls", out_stalls, 5);
        check("t4_stall_row", stall_row, 2);

        // reset during row 1 issue, then a fresh vector
        vec = '{0, 5, 0, -3};
        start_vec(vec, 16);
        load_vec(vec, 1'b0, 0);
        begin
            int k = 0;
            while (!(bus.mac_valid && int'(bus.w_addr) >= 4) && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            check("row1_issue_reached", int'(bus.mac_valid), 1);
        end
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset();
        vec = '{-128, 0, 127, 0};
        run_vec(vec, 16, 2, 24);

        // reset mid-load discards the partial vector
        bus.in_valid = 1'b1;
        bus.in_data  = W'(9);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset();
        vec = '{0, 0, 6, 0};
        run_vec(vec, 12, 1, 20);

        // in_valid held through compute; next vector follows done
        vec  = '{1, 0, 0, 2};
        vec2 = '{3, -1, 0, 0};
        start_vec(vec, 16);
        load_vec(vec, 1'b1, vec2[0]);
        check("b2b_nnz1", int'(bus.nnz), 2);
        wait_done();
        start_vec(vec2, 16);
        load_vec(vec2, 1'b0, 0);
        check("b2b_nnz2", int'(bus.nnz), 2);
        wait_done();

        repeat (4) @(posedge clk);
        #1;
        check("done_total", done_total, 8);
        check("final_queue", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
